// File: rtl/bk_pulse_monitor.sv
// ---------------------------------------------------------------------------
// bk_pulse_monitor
//   Two-channel breakdown feedback monitor. Each raw feedback line is
//   synchronized, glitch-filtered and its high width measured. Accepted
//   pulses are counted. Out-of-range widths and missing or stuck-high pulses
//   raise sticky faults, which are ORed into a registered alarm.
//
// Ports
//   i_clk_25m        25 MHz clock
//   i_rst_n          asynchronous active-low reset
//   i_bk_pulse[1:0]  raw feedback pulses, asynchronous, bit n = channel n
//   i_clr_fault      one-cycle pulse clearing all sticky faults
//   o_width0/1       last measured high width per channel
//   o_pulse_cnt0/1   accepted pulse count per channel (wraps)
//   o_valid[1:0]     one-cycle strobe when o_widthN updates
//   o_fault_width    sticky width-out-of-range fault per channel
//   o_fault_timeout  sticky missing-pulse / stuck-high fault per channel
//   o_alarm          registered OR of all fault bits
//
// Channel FSM
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_ARM   | after reset: wait for startup delay, then for a low level
//   ST_LOW   | filtered line low, waiting for a rising edge
//   ST_HIGH  | filtered line high, width counter running
// ---------------------------------------------------------------------------
module bk_pulse_monitor #(
    parameter int CNT_W          = 19,
    parameter int FILT           = 4,
    parameter int WIDTH_MIN      = 800,
    parameter int WIDTH_MAX      = 950,
    parameter int PERIOD_TIMEOUT = 300000
) (
    input  logic             i_clk_25m,
    input  logic             i_rst_n,
    input  logic [1:0]       i_bk_pulse,
    input  logic             i_clr_fault,
    output logic [CNT_W-1:0] o_width0,
    output logic [CNT_W-1:0] o_width1,
    output logic [15:0]      o_pulse_cnt0,
    output logic [15:0]      o_pulse_cnt1,
    output logic [1:0]       o_valid,
    output logic [1:0]       o_fault_width,
    output logic [1:0]       o_fault_timeout,
    output logic             o_alarm
);

    typedef enum logic [1:0] {ST_ARM, ST_LOW, ST_HIGH} state_t;

    localparam logic [3:0]       FILT_LAST = 4'(FILT - 1);
    // Synchronizer (2) plus filter (FILT) latency: by then the filtered level
    // reflects the pin as seen after reset.
    localparam logic [4:0]       ARM_CYC   = 5'(FILT + 2);
    localparam logic [CNT_W-1:0] W_MIN     = CNT_W'(WIDTH_MIN);
    localparam logic [CNT_W-1:0] W_MAX     = CNT_W'(WIDTH_MAX);
    localparam logic [CNT_W-1:0] T_MAX     = CNT_W'(PERIOD_TIMEOUT);

    logic [4:0]       start_q, start_d;
    logic             armed;
    logic             alarm_q, alarm_d;
    logic [1:0]       valid_all;
    logic [1:0]       fw_all;
    logic [1:0]       ft_all;
    logic [CNT_W-1:0] width_all [2];
    logic [15:0]      pcnt_all  [2];

    assign armed = (start_q == ARM_CYC);

    always_comb begin
        start_d = start_q;
        if (start_q != ARM_CYC) start_d = start_q + 5'd1;
        alarm_d = |{fw_all, ft_all};
    end

    always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            start_q <= start_d;
            alarm_q <= alarm_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             filt_q, filt_d;
        logic [3:0]       fcnt_q, fcnt_d;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] wcnt_q, wcnt_d;
        logic [CNT_W-1:0] tcnt_q, tcnt_d;
        logic             done_q, done_d;
        logic             valid_q, valid_d;
        logic [CNT_W-1:0] width_q, width_d;
        logic [15:0]      pcnt_q, pcnt_d;
        logic             fw_q, fw_d;
        logic             ft_q, ft_d;
        logic             rise_acc;
        logic             width_bad;
        logic             hit_t;

        always_comb begin
            sync1_d = i_bk_pulse[g];
            sync2_d = sync1_q;

            // The filtered level flips on the FILT-th consecutive differing
            // sample; any agreeing sample restarts the run.
            filt_d = filt_q;
            fcnt_d = '0;
            if (sync2_q != filt_q) begin
                if (fcnt_q == FILT_LAST) filt_d = sync2_q;
                else                     fcnt_d = fcnt_q + 4'd1;
            end

            state_d  = state_q;
            wcnt_d   = wcnt_q;
            done_d   = 1'b0;
            rise_acc = 1'b0;
            case (state_q)
                ST_ARM: begin
                    if (armed && !filt_q) state_d = ST_LOW;
                end
                ST_LOW: begin
                    if (filt_q) begin
                        state_d  = ST_HIGH;
                        wcnt_d   = CNT_W'(1);
                        rise_acc = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!filt_q) begin
                        state_d = ST_LOW;
                        done_d  = 1'b1;
                    end else if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_ARM;
            endcase

            // Width counter holds through LOW, so it is still valid the
            // cycle after the falling edge when the result is published.
            valid_d   = done_q;
            width_d   = done_q ? wcnt_q : width_q;
            pcnt_d    = done_q ? (pcnt_q + 16'd1) : pcnt_q;
            width_bad = done_q && ((wcnt_q < W_MIN) || (wcnt_q > W_MAX));

            hit_t = 1'b0;
            if (i_clr_fault || rise_acc) begin
                tcnt_d = '0;
            end else begin
                tcnt_d = (tcnt_q != T_MAX) ? (tcnt_q + CNT_W'(1)) : tcnt_q;
                hit_t  = (tcnt_d == T_MAX);
            end

            // A set in the same cycle as a clear must survive.
            fw_d = (fw_q & ~i_clr_fault) | width_bad;
            ft_d = (ft_q & ~i_clr_fault) | hit_t;
        end

        always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                filt_q  <= 1'b0;
                fcnt_q  <= '0;
                state_q <= ST_ARM;
                wcnt_q  <= '0;
                tcnt_q  <= '0;
                done_q  <= 1'b0;
                valid_q <= 1'b0;
                width_q <= '0;
                pcnt_q  <= '0;
                fw_q    <= 1'b0;
                ft_q    <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                filt_q  <= filt_d;
                fcnt_q  <= fcnt_d;
                state_q <= state_d;
                wcnt_q  <= wcnt_d;
                tcnt_q  <= tcnt_d;
                done_q  <= done_d;
                valid_q <= valid_d;
                width_q <= width_d;
                pcnt_q  <= pcnt_d;
                fw_q    <= fw_d;
                ft_q    <= ft_d;
            end
        end

        assign valid_all[g] = valid_q;
        assign fw_all[g]    = fw_q;
        assign ft_all[g]    = ft_q;
        assign width_all[g] = width_q;
        assign pcnt_all[g]  = pcnt_q;
    end

    assign o_width0        = width_all[0];
    assign o_width1        = width_all[1];
    assign o_pulse_cnt0    = pcnt_all[0];
    assign o_pulse_cnt1    = pcnt_all[1];
    assign o_valid         = valid_all;
    assign o_fault_width   = fw_all;
    assign o_fault_timeout = ft_all;
    assign o_alarm         = alarm_q;

endmodule

// File: doc/bk_pulse_monitor.md
Name: bk_pulse_monitor

Overview:
- Two-channel breakdown feedback monitor in the 25 MHz domain; directly downstream of the breakdown test pulse generator (35 us pulses every 10 ms per channel).
- Synchronizes and glitch-filters each feedback line, then measures high width.
- Counts pulses and raises sticky width-fault and missing/stuck-pulse faults for the control logic.

Parameters:
- CNT_W, 19, width of the width and timeout counters.
- FILT, 4, consecutive identical samples required to change the filtered level (1..15).
- WIDTH_MIN, 800, minimum legal high width in clocks.
- WIDTH_MAX, 950, maximum legal high width in clocks.
- PERIOD_TIMEOUT, 300000, maximum clocks between rising edges, and maximum high time.

Ports:
- i_clk_25m  in  1  25 MHz clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bk_pulse  in  2  raw feedback pulses; bit n = channel n; asynchronous to the clock.
- i_clr_fault  in  1  one-cycle pulse that clears all sticky faults.
- o_width0  out  CNT_W  last measured high width, channel 0.
- o_width1  out  CNT_W  last measured high width, channel 1.
- o_pulse_cnt0  out  16  accepted pulse count, channel 0.
- o_pulse_cnt1  out  16  accepted pulse count, channel 1.
- o_valid  out  2  one-cycle strobe per channel when o_widthN updates.
- o_fault_width  out  2  sticky width-out-of-range fault per channel.
- o_fault_timeout  out  2  sticky missing-pulse or stuck-high fault per channel.
- o_alarm  out  1  registered OR of all four fault bits.

Behaviour:
Reset:
- All outputs 0, sync/filter registers 0, width/timeout/startup counters 0, each channel FSM in ARM.
- Reset is asynchronous and may assert at any cycle, including mid-pulse; the channel then restarts in ARM.

Front end (per channel):
- Two-flop synchronizer feeding the filter.
- Filter: the filtered level f changes only after FILT consecutive synchronized samples differ from f.
- A glitch shorter than FILT cycles is never seen.
- Both edges are delayed equally, so a clean pulse of W cycles gives a measured width of exactly W.

FSM states (per channel):
- ARM: a shared startup counter runs to 2+FILT cycles after reset. Then the FSM goes to LOW if f=0, otherwise it stays in ARM until f=0. A pulse already in progress at reset is discarded, with no valid strobe and no width check.
- LOW: on an f rising edge, width counter := 1, timeout counter := 0, go to HIGH.
- HIGH: the width counter increments each cycle and saturates at all-ones. On an f falling edge, go to LOW and do the following on the next cycle:
  - o_widthN := count.
  - o_valid[n] = 1 for exactly one cycle.
  - o_pulse_cntN += 1, wrapping from 65535 to 0.
  - If count < WIDTH_MIN or count > WIDTH_MAX, set o_fault_width[n].
- o_valid rises exactly 3+FILT cycles after the first low sample at the input pin.

Timeout (per channel):
- The counter runs in every state, is cleared on each accepted rising edge, and saturates at PERIOD_TIMEOUT.
- Reaching PERIOD_TIMEOUT sets o_fault_timeout[n]. This covers both a missing pulse and a line stuck high.
- A stuck-high pulse that eventually falls is still measured and width-checked.

Clear:
- i_clr_fault clears all fault bits and zeroes both timeout counters.
- A fault-set event in the same cycle as the clear wins, so the bit stays 1.

Alarm:
- o_alarm is registered from the fault bits, one cycle behind them.

Channel independence:
- Channels are fully independent; simultaneous events on both channels are each handled with no interaction.

Test Plan:
- Reset, then 875-cycle pulses every 250000 cycles on both channels for 4 periods -> each o_valid fires 4 times, o_widthN=875, o_pulse_cntN=4, no faults, o_alarm=0.
- Channel 0 pulse of 500 cycles -> o_width0=500, o_fault_width[0]=1, o_alarm=1 one cycle later. Channel 1 pulse of 951 cycles -> o_fault_width[1]=1.
- With FILT=4, 3-cycle glitches on channel 1 between pulses -> no o_valid, o_pulse_cnt1 unchanged.
- Stop channel 0 pulses -> o_fault_timeout[0]=1 exactly 300000 cycles after the last accepted rising edge. Hold channel 1 high -> o_fault_timeout[1]=1 after 300000 cycles high.
- i_clr_fault in the same cycle as a width-fault set -> the bit stays 1. Clear alone -> all faults 0 and o_alarm 0 one cycle later.
- Assert reset at pulse cycle 400 and release with the input still high -> no o_valid for that pulse, no fault. The next full 875-cycle pulse is measured as 875.
